// File: rtl/key_event_decoder_pkg.sv
// key_event_decoder_pkg
//   Shared definitions for the key handling slice (key_filter,
//   key_event_decoder, led_ctrl):
//   - 3-bit gesture FSM state encodings
//   - system clock frequency and a ms-to-cycles helper
//   - clog2 / max3 constant functions used to size counters
//   - packed struct grouping the four one-cycle gesture events
package key_event_decoder_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESS1    = 3'd1;
  localparam logic [2:0] S_WAIT2     = 3'd2;
  localparam logic [2:0] S_DBL_HELD  = 3'd3;
  localparam logic [2:0] S_LONG_HOLD = 3'd4;

  typedef struct packed {
    logic short_press;
    logic dbl_click;
    logic long_press;
    logic repeat_tick;
  } evt_t;

  // Divide first so the intermediate product stays within 32 bits.
  function automatic int unsigned ms_to_cyc(input int unsigned ms);
    return (CLK_FREQ_HZ / 1000) * ms;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Per-key gesture classifier fed by key_filter. Turns debounced edges
//   into one-cycle pulses for short press, double click, long press and
//   auto-repeat, plus a registered "held" level.
//
// Ports
//   Clk         system clock
//   Rst_n       asynchronous active-low reset; aborts any gesture silently
//   key_flag    one-cycle pulse on every debounced edge
//   key_state   debounced level, 0 = pressed, 1 = released
//   evt_short   pulse: single short press completed (after the double window)
//   evt_double  pulse: second press inside the double-click window
//   evt_long    pulse: press held for LONG_CYC cycles
//   evt_repeat  pulse: every REP_CYC cycles while a long press is held
//   held        ~key_state delayed by one cycle
//
// Timing (flag present in cycle t):
//   evt_double in t+1, evt_long in t+LONG_CYC, evt_short in t+DBL_CYC
//   after the release, first evt_repeat REP_CYC after evt_long.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYC = ms_to_cyc(1000),
  parameter int unsigned DBL_CYC  = ms_to_cyc(300),
  parameter int unsigned REP_CYC  = ms_to_cyc(200)
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic evt_repeat,
  output logic held
);

  localparam int unsigned CNT_W = clog2(max3(LONG_CYC, DBL_CYC, REP_CYC));

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (LONG_CYC < 2 || DBL_CYC < 2 || REP_CYC < 2) begin : g_param_check
      $error("key_event_decoder: LONG_CYC, DBL_CYC and REP_CYC must all be >= 2");
    end
  endgenerate

  logic             press_edge;
  logic             release_edge;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  evt_t             evt;
  evt_t             evt_nxt;

  assign press_edge   = key_flag & ~key_state;
  assign release_edge = key_flag &  key_state;

  // The counter holds the number of cycles elapsed in the timed phase.
  // On an edge-driven entry (PRESS1, WAIT2) the flag cycle itself is the
  // first elapsed cycle, so the counter is loaded with 1; that makes a
  // phase last exactly its parameter measured from the flag. LONG_HOLD is
  // entered on a terminal count and restarts from 0, which gives a period
  // of exactly REP_CYC between evt_long and each evt_repeat.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_nxt   = '0;
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (press_edge) begin
          state_nxt = S_PRESS1;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        if (release_edge) begin
          state_nxt = S_WAIT2;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == LONG_TC) begin
          state_nxt          = S_LONG_HOLD;
          cnt_nxt            = '0;
          evt_nxt.long_press = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_WAIT2: begin
        if (press_edge) begin
          state_nxt         = S_DBL_HELD;
          cnt_nxt           = '0;
          evt_nxt.dbl_click = 1'b1;
        end else if (cnt == DBL_TC) begin
          state_nxt           = S_IDLE;
          cnt_nxt             = '0;
          evt_nxt.short_press = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_DBL_HELD: begin
        cnt_nxt = '0;
        if (release_edge) state_nxt = S_IDLE;
      end
      S_LONG_HOLD: begin
        if (release_edge) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REP_TC) begin
          cnt_nxt             = '0;
          evt_nxt.repeat_tick = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      evt   <= '0;
      held  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values from before this edge, independent of statement order.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      evt   <= evt_nxt;
      held  <= ~key_state;
    end
  end

  assign evt_short  = evt.short_press;
  assign evt_double = evt.dbl_click;
  assign evt_long   = evt.long_press;
  assign evt_repeat = evt.repeat_tick;

endmodule
